decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage. It consumes the F/D register contents D_PC and D_Ins.
- Contains the 32x32 general register file (GRF), source-operand forwarding, the branch comparator and next-PC generation.
- Drives NPC and D_Flush back to fetch, and registers the D/E pipeline register for the execute stage.
- Supported ISA subset: addu, subu, ori, lui, lw, sw, beq, bne, j, jal, jr, nop (0x00000000).

Parameters:
WB_BYPASS, 1, 1 = a W-stage write is visible to a same-cycle D read (write-first); 0 = the read returns the old GRF value.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
D_Stall  in  1  hazard stall of the D stage (from stall unit)
D_PC  in  32  PC of the instruction in D
D_Ins  in  32  instruction in D
F_PC  in  32  current fetch PC
E_FwdEn  in  1  E-stage result valid for forwarding
E_FwdAddr  in  5  E-stage destination register
E_FwdData  in  32  E-stage result
M_FwdEn  in  1  M-stage result valid
M_FwdAddr  in  5  M-stage destination register
M_FwdData  in  32  M-stage result
W_WE  in  1  GRF write enable
W_Addr  in  5  GRF write address
W_Data  in  32  GRF write data
NPC  out  32  next fetch PC (combinational)
D_Flush  out  1  squash the F/D register (taken control transfer)
E_PC  out  32  D/E register: PC
E_Ins  out  32  D/E register: instruction
E_RS  out  32  D/E register: forwarded rs value
E_RT  out  32  D/E register: forwarded rt value
E_Ext  out  32  D/E register: extended immediate

Behaviour:
- Reset (synchronous): all 32 GRF entries = 0, and E_PC/E_Ins/E_RS/E_RT/E_Ext = 0. Reset overrides every other event in the same cycle.
- GRF write: on the clk edge when W_WE=1 and W_Addr!=0. $0 always reads 0, and writes to $0 are ignored.
- Operand read: rs=D_Ins[25:21], rt=D_Ins[20:16].
- Forwarding priority per operand: E (E_FwdEn and addr match) > M > W (only if WB_BYPASS, W_WE, addr match) > GRF array. Address 0 is never forwarded and yields 0.
- Extension: ori uses zero-extend of imm16; lui uses {imm16,16'h0}; lw/sw/beq/bne use sign-extend; all other instructions give 0.
- Comparator works on the forwarded values: beq taken when RS==RT; bne taken when RS!=RT.
- NPC selection (combinational):
  - beq/bne taken: D_PC+4+(sext(imm16)<<2)
  - j/jal: {D_PC[31:28], D_Ins[25:0], 2'b00}
  - jr: forwarded RS
  - otherwise: F_PC+4
  - Arithmetic is 32-bit and wraps modulo 2^32.
- D_Flush: 1 when D holds a taken beq/bne or any j/jal/jr and D_Stall=0; otherwise 0. There is no delay slot, so the instruction fetched behind a taken transfer is squashed. When D_Stall=1, D_Flush=0 and NPC is don't-care, because fetch holds its PC.
- D/E register on each clk edge:
  - D_Stall=1: insert a bubble; all E_* outputs = 0.
  - Otherwise: capture D_PC, D_Ins, forwarded RS/RT and Ext.
- Latency: one cycle from D inputs to E_* outputs.
- Unknown opcodes pass through as E_Ins with E_Ext=0 and no control transfer.
- Simultaneous events:
  - W write and D read of the same register in one cycle: result follows WB_BYPASS.
  - E and M both match: E wins.
  - A W write lands even while D_Stall=1.
- jal link value (D_PC+4) is computed downstream from E_PC. This block only passes it through.

Test Plan:
- Reset asserted for 2 cycles, then W_WE=1, W_Addr=5, W_Data=0x1234 -> next cycle, with D_Ins=addu $6,$5,$0 (0x00A03021), E_RS=0x1234 and E_RT=0; W_Addr=0 write of 0xFFFF leaves $0 reading 0.
- Forward priority: $3 in GRF=1, M_Fwd{1,3,2}, E_Fwd{1,3,3}, D_Ins=ori $4,$3,0x00FF (0x346400FF) -> E_RS=3, E_Ext=0x000000FF; drop E_FwdEn -> E_RS=2.
- beq $1,$2,+4 (0x10220004) at D_PC=0x3000 with $1=$2=7 -> NPC=0x3014, D_Flush=1; make $2=8 -> NPC=F_PC+4, D_Flush=0.
- j 0x0C01 (0x08000C01) at D_PC=0x3008 -> NPC=0x00003004; jr $31 with $31=0x300C forwarded from M -> NPC=0x300C, D_Flush=1.
- D_Stall=1 with taken bne in D -> D_Flush=0, and after the edge E_PC=E_Ins=E_RS=E_RT=E_Ext=0.
- Reset mid-operation with D_Stall=0 and valid lw (0x8C220010) in D -> next edge all E_* = 0 and GRF cleared.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bundle: F/D inputs, bypass buses, GRF write port, NPC feedback, D/E register.
// Latency: pure wiring, no state.
// Backpressure: D_Stall travels master->slave; there is no other flow control on this bundle.
interface decode_stage_if;
  logic        D_Stall;
  logic [31:0] D_PC;
  logic [31:0] D_Ins;
  logic [31:0] F_PC;
  logic        E_FwdEn;
  logic [4:0]  E_FwdAddr;
  logic [31:0] E_FwdData;
  logic        M_FwdEn;
  logic [4:0]  M_FwdAddr;
  logic [31:0] M_FwdData;
  logic        W_WE;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [31:0] NPC;
  logic        D_Flush;
  logic [31:0] E_PC;
  logic [31:0] E_Ins;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic [31:0] E_Ext;

  // Pipeline side: drives the D-stage inputs, observes NPC/flush and the D/E register
  modport master (
    output D_Stall, D_PC, D_Ins, F_PC,
    output E_FwdEn, E_FwdAddr, E_FwdData,
    output M_FwdEn, M_FwdAddr, M_FwdData,
    output W_WE, W_Addr, W_Data,
    input  NPC, D_Flush, E_PC, E_Ins, E_RS, E_RT, E_Ext
  );

  // Decode stage side
  modport slave (
    input  D_Stall, D_PC, D_Ins, F_PC,
    input  E_FwdEn, E_FwdAddr, E_FwdData,
    input  M_FwdEn, M_FwdAddr, M_FwdData,
    input  W_WE, W_Addr, W_Data,
    output NPC, D_Flush, E_PC, E_Ins, E_RS, E_RT, E_Ext
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: GRF, operand bypass, branch compare, next-PC select, D/E pipeline register.
// Latency: NPC/D_Flush combinational; E_* registered one cycle after the D inputs.
// Backpressure: D_Stall suppresses the flush and loads a bubble into D/E; W writes still land.
module decode_stage #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [31:0] grf_q [32];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [15:0] imm;
  logic [31:0] sext_imm;
  logic [31:0] rs_v;
  logic [31:0] rt_v;
  logic [31:0] ext_v;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, br_taken;
  logic [31:0] npc;

  logic [31:0] e_pc_d, e_ins_d, e_rs_d, e_rt_d, e_ext_d;
  logic [31:0] e_pc_q, e_ins_q, e_rs_q, e_rt_q, e_ext_q;

  assign op       = bus.D_Ins[31:26];
  assign funct    = bus.D_Ins[5:0];
  assign rs_a     = bus.D_Ins[25:21];
  assign rt_a     = bus.D_Ins[20:16];
  assign imm      = bus.D_Ins[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};

  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_jr  = (op == OP_RTYPE) && (funct == FN_JR);

  // Youngest producer wins; $0 is hard-wired to zero and never bypassed.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  a,
    input logic [31:0] grf_v,
    input logic        e_en,
    input logic [4:0]  e_a,
    input logic [31:0] e_d,
    input logic        m_en,
    input logic [4:0]  m_a,
    input logic [31:0] m_d,
    input logic        w_we,
    input logic [4:0]  w_a,
    input logic [31:0] w_d
  );
    logic [31:0] r;
    r = grf_v;
    if (a == 5'd0)                      r = '0;
    else if (e_en && e_a == a)          r = e_d;
    else if (m_en && m_a == a)          r = m_d;
    else if (WB_BYPASS && w_we && w_a == a) r = w_d;
    return r;
  endfunction

  // Resolve both source operands through the bypass network
  always_comb begin
    rs_v = fwd_sel(rs_a, grf_q[rs_a], bus.E_FwdEn, bus.E_FwdAddr, bus.E_FwdData,
                   bus.M_FwdEn, bus.M_FwdAddr, bus.M_FwdData,
                   bus.W_WE, bus.W_Addr, bus.W_Data);
    rt_v = fwd_sel(rt_a, grf_q[rt_a], bus.E_FwdEn, bus.E_FwdAddr, bus.E_FwdData,
                   bus.M_FwdEn, bus.M_FwdAddr, bus.M_FwdData,
                   bus.W_WE, bus.W_Addr, bus.W_Data);
  end

  // Immediate extension by opcode; anything without an immediate gets zero
  always_comb begin
    ext_v = '0;
    case (op)
      OP_ORI:                         ext_v = {16'h0000, imm};
      OP_LUI:                         ext_v = {imm, 16'h0000};
      OP_LW, OP_SW, OP_BEQ, OP_BNE:   ext_v = sext_imm;
      default:                        ext_v = '0;
    endcase
  end

  // Branch compare and next-PC select; fetch ignores NPC while stalled
  always_comb begin
    br_taken = (is_beq && (rs_v == rt_v)) || (is_bne && (rs_v != rt_v));
    npc      = bus.F_PC + 32'd4;
    if (br_taken)          npc = bus.D_PC + 32'd4 + {sext_imm[29:0], 2'b00};
    else if (is_j || is_jal) npc = {bus.D_PC[31:28], bus.D_Ins[25:0], 2'b00};
    else if (is_jr)        npc = rs_v;
  end

  assign bus.NPC     = npc;
  assign bus.D_Flush = (br_taken || is_j || is_jal || is_jr) && !bus.D_Stall;

  // GRF write port; $0 is never written so its reset zero stays put
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (bus.W_WE && bus.W_Addr != 5'd0) begin
      grf_q[bus.W_Addr] <= bus.W_Data;
    end
  end

  // D/E next state: a stall turns the stage into a bubble
  always_comb begin
    e_pc_d  = '0;
    e_ins_d = '0;
    e_rs_d  = '0;
    e_rt_d  = '0;
    e_ext_d = '0;
    if (!bus.D_Stall) begin
      e_pc_d  = bus.D_PC;
      e_ins_d = bus.D_Ins;
      e_rs_d  = rs_v;
      e_rt_d  = rt_v;
      e_ext_d = ext_v;
    end
  end

  // D/E pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      e_pc_q  <= '0;
      e_ins_q <= '0;
      e_rs_q  <= '0;
      e_rt_q  <= '0;
      e_ext_q <= '0;
    end else begin
      e_pc_q  <= e_pc_d;
      e_ins_q <= e_ins_d;
      e_rs_q  <= e_rs_d;
      e_rt_q  <= e_rt_d;
      e_ext_q <= e_ext_d;
    end
  end

  assign bus.E_PC  = e_pc_q;
  assign bus.E_Ins = e_ins_q;
  assign bus.E_RS  = e_rs_q;
  assign bus.E_RT  = e_rt_q;
  assign bus.E_Ext = e_ext_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random instruction stream vs. an ISA-level model.
// Latency: checks NPC/D_Flush before the edge and E_* one cycle later.
// Backpressure: D_Stall is randomised; the model expects bubbles while stalled.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage #(.WB_BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mgrf [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Architectural register value as seen by D this cycle: newest in-flight result first
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.E_FwdEn && bus.E_FwdAddr == a) return bus.E_FwdData;
    if (bus.M_FwdEn && bus.M_FwdAddr == a) return bus.M_FwdData;
    if (bus.W_WE && bus.W_Addr == a) return bus.W_Data;
    return mgrf[a];
  endfunction

  task automatic idle();
    bus.D_Stall = 0; bus.D_PC = 0; bus.D_Ins = 0; bus.F_PC = 0;
    bus.E_FwdEn = 0; bus.E_FwdAddr = 0; bus.E_FwdData = 0;
    bus.M_FwdEn = 0; bus.M_FwdAddr = 0; bus.M_FwdData = 0;
    bus.W_WE = 0; bus.W_Addr = 0; bus.W_Data = 0;
  endtask

  // One clock: called just after a falling edge with inputs set; returns at the next falling edge
  task automatic cycle();
    logic [31:0] ins, a, b, ext, npc, sx, pc;
    logic [5:0]  op;
    logic        xfer, st, rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    ins = bus.D_Ins;
    op  = ins[31:26];
    a   = mread(ins[25:21]);
    b   = mread(ins[20:16]);
    sx  = 32'(signed'(ins[15:0]));
    ext = 32'd0;
    if (op == 6'h0D) ext = 32'(ins[15:0]);
    else if (op == 6'h0F) ext = 32'(ins[15:0]) * 32'h10000;
    else if (op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05) ext = sx;
    npc  = bus.F_PC + 32'd4;
    xfer = 1'b0;
    if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) begin
      npc = bus.D_PC + 32'd4 + sx * 32'd4; xfer = 1'b1;
    end else if (op == 6'h02 || op == 6'h03) begin
      npc = (bus.D_PC & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4; xfer = 1'b1;
    end else if (op == 6'h00 && ins[5:0] == 6'h08) begin
      npc = a; xfer = 1'b1;
    end
    st = bus.D_Stall; rst = reset; we = bus.W_WE; wa = bus.W_Addr; wd = bus.W_Data; pc = bus.D_PC;
    #1;
    check("flush", {31'd0, bus.D_Flush}, {31'd0, xfer && !st});
    if (!st) check("npc", bus.NPC, npc);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mgrf[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      mgrf[wa] = wd;
    end
    if (rst || st) begin
      pc = 0; ins = 0; a = 0; b = 0; ext = 0;
    end
    check("E_PC",  bus.E_PC,  pc);
    check("E_Ins", bus.E_Ins, ins);
    check("E_RS",  bus.E_RS,  a);
    check("E_RT",  bus.E_RT,  b);
    check("E_Ext", bus.E_Ext, ext);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs  = 5'($urandom_range(0, 7));
    rt  = ($urandom_range(0, 2) == 0) ? rs : 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(1, 7));
    imm = 16'($urandom);
    tgt = 26'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h0D, rs, rt, imm};
      3:  return {6'h0F, 5'd0, rt, imm};
      4:  return {6'h23, rs, rt, imm};
      5:  return {6'h2B, rs, rt, imm};
      6:  return {6'h04, rs, rt, imm};
      7:  return {6'h05, rs, rt, imm};
      8:  return {6'h02, tgt};
      9:  return {6'h03, tgt};
      10: return {6'h00, rs, 15'd0, 6'h08};
      11: return 32'd0;
      default: return {6'h3F, tgt};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mgrf[i] = 32'hDEAD_BEEF;
    idle();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_E_Ins", bus.E_Ins, 32'd0);

    // GRF write then read; write to $0 discarded
    reset = 1'b0;
    bus.W_WE = 1; bus.W_Addr = 5; bus.W_Data = 32'h1234;
    cycle();
    bus.W_Addr = 0; bus.W_Data = 32'hFFFF; bus.D_Ins = 32'h00A03021;
    cycle();
    check("tp_wr_rs", bus.E_RS, 32'h1234);
    check("tp_wr_rt", bus.E_RT, 32'h0);

    // same-cycle W write is visible to D
    bus.W_Addr = 7; bus.W_Data = 32'hABCD; bus.D_Ins = 32'h00E03021;
    cycle();
    check("tp_wb_bypass", bus.E_RS, 32'hABCD);

    // forward priority E > M > GRF
    bus.W_Addr = 3; bus.W_Data = 1; bus.D_Ins = 0;
    cycle();
    bus.W_WE = 0;
    bus.M_FwdEn = 1; bus.M_FwdAddr = 3; bus.M_FwdData = 2;
    bus.E_FwdEn = 1; bus.E_FwdAddr = 3; bus.E_FwdData = 3;
    bus.D_Ins = 32'h346400FF;
    cycle();
    check("tp_fwd_E", bus.E_RS, 32'd3);
    check("tp_ori_ext", bus.E_Ext, 32'h000000FF);
    bus.E_FwdEn = 0;
    cycle();
    check("tp_fwd_M", bus.E_RS, 32'd2);
    bus.M_FwdEn = 0;

    // beq taken / not taken
    bus.W_WE = 1; bus.W_Addr = 1; bus.W_Data = 7; bus.D_Ins = 0;
    cycle();
    bus.W_Addr = 2;
    cycle();
    bus.W_WE = 0;
    bus.D_PC = 32'h3000; bus.F_PC = 32'h3004; bus.D_Ins = 32'h10220004;
    #1;
    check("tp_beq_npc", bus.NPC, 32'h3014);
    check("tp_beq_flush", {31'd0, bus.D_Flush}, 32'd1);
    cycle();
    bus.W_WE = 1; bus.W_Addr = 2; bus.W_Data = 8; bus.D_Ins = 0;
    cycle();
    bus.W_WE = 0; bus.D_Ins = 32'h10220004;
    #1;
    check("tp_beq_nt_npc", bus.NPC, 32'h3008);
    check("tp_beq_nt_flush", {31'd0, bus.D_Flush}, 32'd0);
    cycle();

    // j and jr
    bus.D_PC = 32'h3008; bus.F_PC = 32'h300C; bus.D_Ins = 32'h08000C01;
    #1;
    check("tp_j_npc", bus.NPC, 32'h3004);
    cycle();
    bus.M_FwdEn = 1; bus.M_FwdAddr = 31; bus.M_FwdData = 32'h300C; bus.D_Ins = 32'h03E00008;
    #1;
    check("tp_jr_npc", bus.NPC, 32'h300C);
    check("tp_jr_flush", {31'd0, bus.D_Flush}, 32'd1);
    cycle();
    bus.M_FwdEn = 0;

    // stall with taken bne: no flush, bubble into D/E
    bus.D_Stall = 1; bus.D_PC = 32'h3010; bus.D_Ins = 32'h14220004;
    #1;
    check("tp_stall_flush", {31'd0, bus.D_Flush}, 32'd0);
    cycle();
    check("tp_stall_E_PC", bus.E_PC, 32'd0);
    check("tp_stall_E_Ins", bus.E_Ins, 32'd0);
    bus.D_Stall = 0;

    // reset mid-operation clears D/E and GRF
    bus.D_Ins = 32'h8C220010; reset = 1;
    cycle();
    check("tp_rst_E_Ins", bus.E_Ins, 32'd0);
    check("tp_rst_E_Ext", bus.E_Ext, 32'd0);
    reset = 0; bus.D_Ins = 32'h00A13021;
    cycle();
    check("tp_rst_grf5", bus.E_RS, 32'd0);
    check("tp_rst_grf1", bus.E_RT, 32'd0);

    // random stream
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      bus.D_Stall   = ($urandom_range(0, 5) == 0);
      bus.D_PC      = $urandom & 32'hFFFF_FFFC;
      bus.F_PC      = $urandom & 32'hFFFF_FFFC;
      bus.D_Ins     = rand_ins();
      bus.E_FwdEn   = 1'($urandom_range(0, 1));
      bus.E_FwdAddr = 5'($urandom_range(0, 7));
      bus.E_FwdData = $urandom;
      bus.M_FwdEn   = 1'($urandom_range(0, 1));
      bus.M_FwdAddr = 5'($urandom_range(0, 7));
      bus.M_FwdData = $urandom;
      bus.W_WE      = 1'($urandom_range(0, 1));
      bus.W_Addr    = 5'($urandom_range(0, 7));
      bus.W_Data    = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
